// File: rtl/vec_mag_pkg.sv
// Shared types and width helpers for the vector-magnitude engine.
// The width helpers are also used by the downstream normalisation logic.
package vec_mag_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    SQRT = 2'd2,
    DONE = 2'd3
  } state_t;

  // Width of the sum of squares; cannot overflow for num_ch components.
  function automatic int calc_sum_w(input int width, input int num_ch);
    return 2 * width + $clog2(num_ch);
  endfunction

  // Width of floor(sqrt()) of a sum_w-bit value.
  function automatic int calc_root_w(input int sum_w);
    return (sum_w + 1) / 2;
  endfunction

endpackage

// File: rtl/vec_mag_isqrt_iter.sv
// Restoring bit-serial integer square root, one root bit per cycle, MSB first.
// start loads the radicand; 'done' is high in the cycle whose clock edge
// writes the final root (and remainder) into the output registers.
// The remainder output exists only when VEC_MAG_REM_EN is defined.
module isqrt_iter
  import vec_mag_pkg::*;
#(
  parameter int ROOT_W = 17,
  localparam int CNT_W = $clog2(ROOT_W + 1)
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  start,
  input  logic [2*ROOT_W-1:0]   radicand,
  output logic                  done,
  output logic [ROOT_W-1:0]     root
`ifdef VEC_MAG_REM_EN
  ,
  output logic [ROOT_W:0]       rem
`endif
);

  logic [2*ROOT_W-1:0] rad_q;
  logic [ROOT_W:0]     rem_q;
  logic [ROOT_W-1:0]   root_q;
  logic [CNT_W-1:0]    cnt_q;

  logic [ROOT_W+2:0]   rem_sh;
  logic [ROOT_W+2:0]   trial;
  logic [ROOT_W+2:0]   rem_sel;
  logic                fits;
  logic [ROOT_W:0]     rem_nx;
  logic [ROOT_W-1:0]   root_nx;

  // One restoring step: bring down two radicand bits, try (root<<2)|1.
  always_comb begin
    rem_sh  = {rem_q, rad_q[2*ROOT_W-1 -: 2]};
    trial   = {1'b0, root_q, 2'b01};
    fits    = (rem_sh >= trial);
    rem_sel = fits ? (rem_sh - trial) : rem_sh;
    rem_nx  = (ROOT_W+1)'(rem_sel);
    root_nx = (root_q << 1) | ROOT_W'(fits);
    done    = (cnt_q == CNT_W'(1));
  end

  // Working registers; cnt_q counts remaining root bits down to zero.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rad_q  <= '0;
      rem_q  <= '0;
      root_q <= '0;
      cnt_q  <= '0;
    end else if (start) begin
      rad_q  <= radicand;
      rem_q  <= '0;
      root_q <= '0;
      cnt_q  <= CNT_W'(ROOT_W);
    end else if (cnt_q != '0) begin
      rad_q  <= rad_q << 2;
      rem_q  <= rem_nx;
      root_q <= root_nx;
      cnt_q  <= cnt_q - 1'b1;
    end
  end

  // Result registers change only on the final step and hold otherwise.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      root <= '0;
`ifdef VEC_MAG_REM_EN
      rem  <= '0;
`endif
    end else if (done) begin
      root <= root_nx;
`ifdef VEC_MAG_REM_EN
      rem  <= rem_nx;
`endif
    end
  end

endmodule

// File: rtl/vec_mag.sv
// Vector-magnitude engine: floor(sqrt(sum of squares)) of one NUM_CH-component
// vector per valid/ready transaction, using one shared squarer and a
// bit-serial square root. Optional remainder output: define VEC_MAG_REM_EN.
//
// state | meaning
// IDLE  | ready for a vector; results from the last run held
// ACC   | squaring one component per cycle into the accumulator
// SQRT  | bit-serial root running, ROOT_W cycles
// DONE  | result valid, waiting for result_ready_in
module vec_mag
  import vec_mag_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int NUM_CH = 2,
  localparam int SUM_W  = calc_sum_w(WIDTH, NUM_CH),
  localparam int ROOT_W = calc_root_w(SUM_W)
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [NUM_CH*WIDTH-1:0] data_in,
  input  logic                    data_valid_in,
  output logic                    ready_out,
  output logic [ROOT_W-1:0]       root_out,
`ifdef VEC_MAG_REM_EN
  output logic [ROOT_W:0]         rem_out,
`endif
  output logic                    data_valid_out,
  input  logic                    result_ready_in,
  output logic                    busy_out
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_t                  state_q, state_d;
  logic [NUM_CH*WIDTH-1:0] data_q;
  logic [SUM_W-1:0]        acc_q;
  logic [SUM_W-1:0]        acc_nx;
  logic [IDX_W-1:0]        idx_q;
  logic [WIDTH-1:0]        comp;
  logic [2*WIDTH-1:0]      sq;
  logic [2*ROOT_W-1:0]     radicand;
  logic                    last_comp;
  logic                    sq_start;
  logic                    sq_done;

  // Component select, square and accumulate for the current index.
  always_comb begin
    comp = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (idx_q == IDX_W'(k)) comp = data_q[k*WIDTH +: WIDTH];
    end
    sq        = {{WIDTH{1'b0}}, comp} * {{WIDTH{1'b0}}, comp};
    acc_nx    = acc_q + SUM_W'(sq);
    last_comp = (idx_q == IDX_W'(NUM_CH - 1));
    // The root is started with the final sum while the last square is added,
    // so no cycle is lost between ACC and SQRT.
    sq_start  = (state_q == ACC) && last_comp;
    radicand  = (2*ROOT_W)'(acc_nx);
  end

  // State register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d        = state_q;
    ready_out      = 1'b0;
    data_valid_out = 1'b0;
    busy_out       = 1'b1;
    case (state_q)
      IDLE: begin
        ready_out = 1'b1;
        busy_out  = 1'b0;
        if (data_valid_in) state_d = ACC;
      end
      ACC:  if (last_comp) state_d = SQRT;
      SQRT: if (sq_done) state_d = DONE;
      DONE: begin
        data_valid_out = 1'b1;
        if (result_ready_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Vector capture and accumulate loop.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      data_q <= '0;
      acc_q  <= '0;
      idx_q  <= '0;
    end else if (state_q == IDLE && data_valid_in) begin
      data_q <= data_in;
      acc_q  <= '0;
      idx_q  <= '0;
    end else if (state_q == ACC) begin
      acc_q  <= acc_nx;
      idx_q  <= idx_q + 1'b1;
    end
  end

  isqrt_iter #(.ROOT_W(ROOT_W)) u_isqrt (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .start    (sq_start),
    .radicand (radicand),
    .done     (sq_done),
    .root     (root_out)
`ifdef VEC_MAG_REM_EN
    ,
    .rem      (rem_out)
`endif
  );

endmodule

// File: tb/tb_vec_mag.sv
// Self-checking bench for vec_mag: default instance checked every cycle
// against a behavioural model, plus a NUM_CH=3/WIDTH=8 instance checked
// with directed literals.
module tb_vec_mag;

  localparam int WIDTH  = 16;
  localparam int NUM_CH = 2;
  localparam int ROOT_W = 17;
  localparam int LAT    = NUM_CH + ROOT_W;

  logic clk_100mhz = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk_100mhz = ~clk_100mhz;

  logic [31:0]       data_in;
  logic              data_valid_in;
  logic              result_ready_in;
  logic              ready_out;
  logic [ROOT_W-1:0] root_out;
  logic              data_valid_out;
  logic              busy_out;
`ifdef VEC_MAG_REM_EN
  logic [ROOT_W:0]   rem_out;
`endif

  logic [23:0] data3;
  logic        valid3;
  logic        rr3;
  logic        ready3;
  logic [8:0]  root3;
  logic        dvalid3;
  logic        busy3;
`ifdef VEC_MAG_REM_EN
  logic [9:0]  rem3;
`endif

  vec_mag #(.WIDTH(WIDTH), .NUM_CH(NUM_CH)) dut (
    .clk_in          (clk_100mhz),
    .rst_in          (rst_n),
    .data_in         (data_in),
    .data_valid_in   (data_valid_in),
    .ready_out       (ready_out),
    .root_out        (root_out),
`ifdef VEC_MAG_REM_EN
    .rem_out         (rem_out),
`endif
    .data_valid_out  (data_valid_out),
    .result_ready_in (result_ready_in),
    .busy_out        (busy_out)
  );

  vec_mag #(.WIDTH(8), .NUM_CH(3)) dut3 (
    .clk_in          (clk_100mhz),
    .rst_in          (rst_n),
    .data_in         (data3),
    .data_valid_in   (valid3),
    .ready_out       (ready3),
    .root_out        (root3),
`ifdef VEC_MAG_REM_EN
    .rem_out         (rem3),
`endif
    .data_valid_out  (dvalid3),
    .result_ready_in (rr3),
    .busy_out        (busy3)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always @(posedge clk_100mhz) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint unsigned isqrt_ref(input longint unsigned s);
    longint unsigned lo, hi, mid;
    lo = 0;
    hi = 64'd1 << 20;
    while (lo < hi) begin
      mid = (lo + hi + 1) >> 1;
      if (mid * mid <= s) lo = mid;
      else hi = mid - 1;
    end
    return lo;
  endfunction

  // Behavioural model and per-cycle compare for the default instance.
  bit              m_pending = 1'b0;
  int              m_due = 0;
  longint unsigned m_root = 0, m_rem = 0, held_root = 0, held_rem = 0;

  always @(negedge clk_100mhz) begin : cmp
    logic            exp_valid;
    longint unsigned s, c;
    if (!rst_n) begin
      check("rst_valid", data_valid_out, 1'b0);
      check("rst_ready", ready_out, 1'b1);
      check("rst_busy", busy_out, 1'b0);
      check("rst_root", root_out, 0);
`ifdef VEC_MAG_REM_EN
      check("rst_rem", rem_out, 0);
`endif
      m_pending = 1'b0;
      held_root = 0;
      held_rem  = 0;
    end else begin
      exp_valid = m_pending && (cyc >= m_due);
      check("valid", data_valid_out, exp_valid);
      check("ready", ready_out, !m_pending);
      check("busy", busy_out, m_pending);
      check("root", root_out, exp_valid ? m_root : held_root);
`ifdef VEC_MAG_REM_EN
      check("rem", rem_out, exp_valid ? m_rem : held_rem);
`endif
      if (exp_valid && result_ready_in) begin
        held_root = m_root;
        held_rem  = m_rem;
        m_pending = 1'b0;
      end else if (!m_pending && data_valid_in) begin
        s = 0;
        for (int k = 0; k < NUM_CH; k++) begin
          c = data_in[k*WIDTH +: WIDTH];
          s += c * c;
        end
        m_root    = isqrt_ref(s);
        m_rem     = s - m_root * m_root;
        m_pending = 1'b1;
        m_due     = cyc + 1 + LAT;
      end
    end
  end

  task automatic send(input logic [31:0] d, output int acc_cyc);
    bit got;
    got = 1'b0;
    acc_cyc = -1;
    @(posedge clk_100mhz); #1;
    data_in = d;
    data_valid_in = 1'b1;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk_100mhz);
      if (ready_out) begin
        got = 1'b1;
        acc_cyc = cyc + 1;
      end
    end
    check("accept_seen", got, 1'b1);
    @(posedge clk_100mhz); #1;
    data_valid_in = 1'b0;
  endtask

  task automatic wait_valid(output int v_cyc);
    bit got;
    got = 1'b0;
    v_cyc = -1;
    for (int t = 0; t < 400 && !got; t++) begin
      @(negedge clk_100mhz);
      if (data_valid_out) begin
        got = 1'b1;
        v_cyc = cyc;
      end
    end
    check("result_seen", got, 1'b1);
  endtask

  task automatic directed(input string name, input logic [31:0] d,
                          input logic [63:0] er, input logic [63:0] erem);
    int a, v;
    send(d, a);
    wait_valid(v);
    check({name, "_lat"}, v - a, LAT);
    check({name, "_root"}, root_out, er);
`ifdef VEC_MAG_REM_EN
    check({name, "_rem"}, rem_out, erem);
`else
    if (erem > 64'd2 * er) check({name, "_rem_bound"}, erem, 64'd2 * er);
`endif
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: run did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int  a, v, a2, cons, prev, a3, v3;
    bit  got;
    data_in = '0;
    data_valid_in = 1'b0;
    result_ready_in = 1'b1;
    data3 = '0;
    valid3 = 1'b0;
    rr3 = 1'b1;

    #1 rst_n = 1'b0;
    #1;
    check("init_ready", ready_out, 1'b1);
    check("init_valid", data_valid_out, 1'b0);
    check("init_busy", busy_out, 1'b0);
    check("init_root", root_out, 0);
    check("init3_ready", ready3, 1'b1);
    check("init3_root", root3, 0);
    #20 rst_n = 1'b1;

    check("model_pin_25", isqrt_ref(64'd25), 5);
    check("model_pin_max", isqrt_ref(64'd8589672450), 92680);
    check("model_pin_48", isqrt_ref(64'd48), 6);

    directed("v43",  {16'd4, 16'd3}, 5, 0);
    directed("vmax", 32'hFFFF_FFFF, 92680, 90050);
    directed("v11",  {16'd1, 16'd1}, 1, 1);
    directed("v00",  32'd0, 0, 0);

    // Three-channel, 8-bit instance: 2,3,6 -> 7
    @(posedge clk_100mhz); #1;
    data3 = {8'd6, 8'd3, 8'd2};
    valid3 = 1'b1;
    got = 1'b0;
    a3 = -1;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clk_100mhz);
      if (ready3) begin got = 1'b1; a3 = cyc + 1; end
    end
    check("ch3_accept", got, 1'b1);
    @(posedge clk_100mhz); #1;
    valid3 = 1'b0;
    got = 1'b0;
    v3 = -1;
    for (int t = 0; t < 100 && !got; t++) begin
      @(negedge clk_100mhz);
      if (dvalid3) begin got = 1'b1; v3 = cyc; end
    end
    check("ch3_result_seen", got, 1'b1);
    check("ch3_lat", v3 - a3, 12);
    check("ch3_root", root3, 7);
`ifdef VEC_MAG_REM_EN
    check("ch3_rem", rem3, 0);
`endif

    // Backpressure with a held source vector
    send({16'd12, 16'd5}, a);
    result_ready_in = 1'b0;
    data_in = {16'd8, 16'd6};
    data_valid_in = 1'b1;
    wait_valid(v);
    check("bp_lat", v - a, LAT);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", data_valid_out, 1'b1);
      check("bp_root", root_out, 13);
      check("bp_ready", ready_out, 1'b0);
`ifdef VEC_MAG_REM_EN
      check("bp_rem", rem_out, 0);
`endif
      @(negedge clk_100mhz);
    end
    @(posedge clk_100mhz); #1;
    result_ready_in = 1'b1;
    @(negedge clk_100mhz);
    cons = cyc + 1;
    got = 1'b0;
    a2 = -1;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clk_100mhz);
      if (ready_out) begin got = 1'b1; a2 = cyc + 1; end
    end
    check("bp_held_accept", got, 1'b1);
    check("bp_accept_gap", a2 - cons, 1);
    @(posedge clk_100mhz); #1;
    data_valid_in = 1'b0;
    wait_valid(v);
    check("bp2_lat", v - a2, LAT);
    check("bp2_root", root_out, 10);

    // Reset in the middle of SQRT
    send({16'd4, 16'd3}, a);
    repeat (5) @(posedge clk_100mhz);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", data_valid_out, 1'b0);
    check("mid_rst_root", root_out, 0);
    check("mid_rst_busy", busy_out, 1'b0);
    check("mid_rst_ready", ready_out, 1'b1);
`ifdef VEC_MAG_REM_EN
    check("mid_rst_rem", rem_out, 0);
`endif
    @(posedge clk_100mhz); #3 rst_n = 1'b1;
    directed("after_rst", {16'd3, 16'd4}, 5, 0);

    // Random vectors with random output stalls
    for (int i = 0; i < 8; i++) begin
      send($urandom, a);
      result_ready_in = 1'b0;
      wait_valid(v);
      check("rnd_lat", v - a, LAT);
      repeat ($urandom_range(0, 3)) @(negedge clk_100mhz);
      @(posedge clk_100mhz); #1;
      result_ready_in = 1'b1;
    end

    // Back-to-back with the source always valid
    @(posedge clk_100mhz); #1;
    prev = -1;
    data_in = $urandom;
    data_valid_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      got = 1'b0;
      a = -1;
      for (int t = 0; t < 100 && !got; t++) begin
        @(negedge clk_100mhz);
        if (ready_out) begin got = 1'b1; a = cyc + 1; end
      end
      check("b2b_accept", got, 1'b1);
      if (i > 0) check("b2b_ii", a - prev, NUM_CH + ROOT_W + 2);
      prev = a;
      @(posedge clk_100mhz); #1;
      data_in = $urandom;
    end
    data_valid_in = 1'b0;
    wait_valid(v);
    repeat (4) @(posedge clk_100mhz);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
